tmu2_hdivarb: RTL and testbench

Two-requester round-robin arbiter that shares the single horizontal-division-operand stage of the TMU2 pipeline between two vertical interpolation lanes (A, B). It accepts one operand token per cycle from the granted lane and registers it into a one-entry output stage. The output stage carries a source tag so results can be steered back to the issuing lane. It also provides a grant hold for reconfiguration and per-lane accepted-token counters.

---
 rtl/tmu2_hdivarb_if.sv | 37 +++
 rtl/tmu2_hdivarb.sv | 124 ++++++++++++
 tb/tb_tmu2_hdivarb.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/tmu2_hdivarb_if.sv
// Handshake and payload bundle for the TMU2 horizontal-division arbiter.
// Carries the two upstream lane ports (A, B) and the single downstream pipe port.
//   slave  : the arbiter's view (lane strobes/payload in, acks out, pipe out)
//   master : the surrounding logic's view (drives lanes, consumes pipe)
interface tmu2_hdivarb_if;
  // lane A
  logic               a_stb_i, a_ack_o;
  logic signed [11:0] a_x, a_y;
  logic signed [17:0] a_tsx, a_tsy, a_tex, a_tey;
  // lane B
  logic               b_stb_i, b_ack_o;
  logic signed [11:0] b_x, b_y;
  logic signed [17:0] b_tsx, b_tsy, b_tex, b_tey;
  // downstream pipe
  logic               pipe_stb_o, pipe_ack_i;
  logic signed [11:0] x, y;
  logic signed [17:0] tsx, tsy, tex, tey;
  logic               src_o;

  modport slave (
    input  a_stb_i, a_x, a_y, a_tsx, a_tsy, a_tex, a_tey,
    output a_ack_o,
    input  b_stb_i, b_x, b_y, b_tsx, b_tsy, b_tex, b_tey,
    output b_ack_o,
    output pipe_stb_o, x, y, tsx, tsy, tex, tey, src_o,
    input  pipe_ack_i
  );

  modport master (
    output a_stb_i, a_x, a_y, a_tsx, a_tsy, a_tex, a_tey,
    input  a_ack_o,
    output b_stb_i, b_x, b_y, b_tsx, b_tsy, b_tex, b_tey,
    input  b_ack_o,
    input  pipe_stb_o, x, y, tsx, tsy, tex, tey, src_o,
    output pipe_ack_i
  );
endinterface

// File: rtl/tmu2_hdivarb.sv
// Two-lane round-robin arbiter feeding the TMU2 horizontal-division operand stage.
// One token per cycle is taken from the granted lane into a one-entry output
// register tagged with its source lane.
// Ports:
//   sys_clk, sys_rst  clock, async active-low reset
//   hold              stop issuing grants (output stage still drains)
//   cnt_clear         synchronous clear of the accepted-token counters
//   busy              output stage full or any lane requesting
//   cnt_a, cnt_b      accepted-token counters per lane (wrapping)
//   bus               lane A/B handshakes + payload in, pipe handshake + payload out
module tmu2_hdivarb #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             hold,
  input  logic             cnt_clear,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  tmu2_hdivarb_if.slave    bus
);

  typedef struct packed {
    logic signed [11:0] x, y;
    logic signed [17:0] tsx, tsy, tex, tey;
  } payload_t;

  localparam logic LANE_A = 1'b0;
  localparam logic LANE_B = 1'b1;

  payload_t         pay_a, pay_b;
  payload_t         pay_q, pay_d;
  logic             stb_q, stb_d;
  logic             src_q, src_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  logic can_load, gnt_vld, gnt_lane, acc_a, acc_b;

  assign pay_a = '{bus.a_x, bus.a_y, bus.a_tsx, bus.a_tsy, bus.a_tex, bus.a_tey};
  assign pay_b = '{bus.b_x, bus.b_y, bus.b_tsx, bus.b_tsy, bus.b_tex, bus.b_tey};

  assign can_load = ~stb_q | bus.pipe_ack_i;

  // Grant: ties go to the lane that did not win last time.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_lane = LANE_A;
    if (can_load && !hold) begin
      if (bus.a_stb_i && bus.b_stb_i) begin
        gnt_vld  = 1'b1;
        gnt_lane = ~last_q;
      end else if (bus.a_stb_i) begin
        gnt_vld  = 1'b1;
        gnt_lane = LANE_A;
      end else if (bus.b_stb_i) begin
        gnt_vld  = 1'b1;
        gnt_lane = LANE_B;
      end
    end
  end

  assign bus.a_ack_o = gnt_vld & (gnt_lane == LANE_A) & bus.a_stb_i;
  assign bus.b_ack_o = gnt_vld & (gnt_lane == LANE_B) & bus.b_stb_i;
  assign acc_a = bus.a_stb_i & bus.a_ack_o;
  assign acc_b = bus.b_stb_i & bus.b_ack_o;

  always_comb begin
    stb_d  = stb_q;
    pay_d  = pay_q;
    src_d  = src_q;
    last_d = last_q;
    if (gnt_vld) begin
      stb_d  = 1'b1;
      pay_d  = (gnt_lane == LANE_B) ? pay_b : pay_a;
      src_d  = gnt_lane;
      last_d = gnt_lane;
    end else if (bus.pipe_ack_i) begin
      stb_d  = 1'b0;
    end
  end

  // A clear coinciding with an accept leaves the counter at 1, not 0.
  always_comb begin
    cnt_a_d = cnt_a_q + CNT_W'(acc_a);
    cnt_b_d = cnt_b_q + CNT_W'(acc_b);
    if (cnt_clear) begin
      cnt_a_d = CNT_W'(acc_a);
      cnt_b_d = CNT_W'(acc_b);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      stb_q   <= 1'b0;
      pay_q   <= '0;
      src_q   <= LANE_A;
      last_q  <= LANE_B;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      stb_q   <= stb_d;
      pay_q   <= pay_d;
      src_q   <= src_d;
      last_q  <= last_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign bus.pipe_stb_o = stb_q;
  assign bus.src_o      = src_q;
  assign bus.x          = pay_q.x;
  assign bus.y          = pay_q.y;
  assign bus.tsx        = pay_q.tsx;
  assign bus.tsy        = pay_q.tsy;
  assign bus.tex        = pay_q.tex;
  assign bus.tey        = pay_q.tey;
  assign cnt_a          = cnt_a_q;
  assign cnt_b          = cnt_b_q;
  assign busy           = stb_q | bus.a_stb_i | bus.b_stb_i;

endmodule

// File: tb/tb_tmu2_hdivarb.sv
// Directed self-checking bench for tmu2_hdivarb (CNT_W=4).
// Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
module tb_tmu2_hdivarb;
  localparam int CNT_W = 4;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             hold, cnt_clear, busy;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  int               checks = 0;
  int               errors = 0;

  tmu2_hdivarb_if bus();

  tmu2_hdivarb #(.CNT_W(CNT_W)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .hold     (hold),
    .cnt_clear(cnt_clear),
    .busy     (busy),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b0; hold = 1'b0; cnt_clear = 1'b0;
    bus.a_stb_i = 1'b0; bus.b_stb_i = 1'b0; bus.pipe_ack_i = 1'b0;
    bus.a_x = '0; bus.a_y = '0; bus.a_tsx = '0; bus.a_tsy = '0; bus.a_tex = '0; bus.a_tey = '0;
    bus.b_x = '0; bus.b_y = '0; bus.b_tsx = '0; bus.b_tsy = '0; bus.b_tex = '0; bus.b_tey = '0;
    #3;
    checks++; if (bus.pipe_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %0b want 0", bus.pipe_stb_o); end
    checks++; if (bus.src_o !== 1'b0) begin errors++; $display("FAIL reset_src: got %0b want 0", bus.src_o); end
    checks++; if (bus.x !== 12'h000 || bus.tsx !== 18'h0) begin errors++; $display("FAIL reset_payload: got x=%0h tsx=%0h want 0", bus.x, bus.tsx); end
    checks++; if (cnt_a !== 4'd0 || cnt_b !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt_a, cnt_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tick();
    sys_rst = 1'b1;
    // load one B token and keep it stalled
    bus.b_stb_i = 1'b1; bus.b_x = 12'hFF9;
    tick();
    bus.b_stb_i = 1'b0;
    checks++; if (bus.pipe_stb_o !== 1'b1 || bus.src_o !== 1'b1 || cnt_b !== 4'd1) begin errors++; $display("FAIL preload: got stb=%0b src=%0b cnt_b=%0d want 1/1/1", bus.pipe_stb_o, bus.src_o, cnt_b); end
    #3 sys_rst = 1'b0;
    #1;
    checks++; if (bus.pipe_stb_o !== 1'b0 || bus.src_o !== 1'b0) begin errors++; $display("FAIL async_rst_stb_src: got stb=%0b src=%0b want 0/0", bus.pipe_stb_o, bus.src_o); end
    checks++; if (cnt_b !== 4'd0 || bus.x !== 12'h000) begin errors++; $display("FAIL async_rst_cnt_x: got cnt_b=%0d x=%0h want 0/0", cnt_b, bus.x); end
    #1 sys_rst = 1'b1;
    tick();
    bus.a_stb_i = 1'b1; bus.b_stb_i = 1'b1; bus.a_x = 12'h005; bus.pipe_ack_i = 1'b1;
    #1;
    checks++; if (bus.a_ack_o !== 1'b1 || bus.b_ack_o !== 1'b0) begin errors++; $display("FAIL first_tie_ack: got a=%0b b=%0b want 1/0", bus.a_ack_o, bus.b_ack_o); end
    tick();
    checks++; if (bus.src_o !== 1'b0 || bus.x !== 12'h005 || cnt_a !== 4'd1) begin errors++; $display("FAIL first_tie_out: got src=%0b x=%0h cnt_a=%0d want 0/5/1", bus.src_o, bus.x, cnt_a); end
    bus.a_stb_i = 1'b0; bus.b_stb_i = 1'b0;
    tick();
  endtask

  task automatic test_alternate();
    logic exp_b;
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    checks++; if (cnt_a !== 4'd0 || cnt_b !== 4'd0) begin errors++; $display("FAIL clear_idle: got %0d/%0d want 0/0", cnt_a, cnt_b); end
    bus.a_stb_i = 1'b1; bus.b_stb_i = 1'b1; bus.a_x = 12'h005; bus.b_x = 12'hFF9;
    exp_b = 1'b1; // A won last, so B wins the next tie
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (bus.a_ack_o !== ~exp_b || bus.b_ack_o !== exp_b) begin errors++; $display("FAIL alt_ack[%0d]: got a=%0b b=%0b want %0b/%0b", i, bus.a_ack_o, bus.b_ack_o, ~exp_b, exp_b); end
      tick();
      checks++; if (bus.x !== (exp_b ? 12'hFF9 : 12'h005) || bus.src_o !== exp_b || bus.pipe_stb_o !== 1'b1) begin errors++; $display("FAIL alt_out[%0d]: got x=%0h src=%0b stb=%0b want src=%0b", i, bus.x, bus.src_o, bus.pipe_stb_o, exp_b); end
      exp_b = ~exp_b;
    end
    checks++; if (cnt_a !== 4'd3 || cnt_b !== 4'd3) begin errors++; $display("FAIL alt_cnt: got %0d/%0d want 3/3", cnt_a, cnt_b); end
    bus.a_stb_i = 1'b0; bus.b_stb_i = 1'b0;
    tick();
  endtask

  task automatic test_only_b();
    bus.b_stb_i = 1'b1; bus.b_tsx = 18'h1FFFF; bus.b_tey = 18'h20000;
    for (int i = 0; i < 3; i++) begin
      bus.b_x = 12'(i + 1);
      #1;
      checks++; if (bus.b_ack_o !== 1'b1 || bus.a_ack_o !== 1'b0) begin errors++; $display("FAIL onlyb_ack[%0d]: got a=%0b b=%0b want 0/1", i, bus.a_ack_o, bus.b_ack_o); end
      tick();
      checks++; if (bus.tsx !== 18'h1FFFF || bus.tey !== 18'h20000 || bus.x !== 12'(i + 1) || bus.src_o !== 1'b1) begin errors++; $display("FAIL onlyb_out[%0d]: got tsx=%0h tey=%0h x=%0h src=%0b", i, bus.tsx, bus.tey, bus.x, bus.src_o); end
    end
    bus.b_stb_i = 1'b0; bus.b_tsx = '0; bus.b_tey = '0;
    tick();
  endtask

  task automatic test_backpressure();
    bus.a_stb_i = 1'b1; bus.b_stb_i = 1'b1; bus.a_x = 12'h005; bus.b_x = 12'hFF9;
    tick(); // last grant was B, so A loads
    checks++; if (bus.pipe_stb_o !== 1'b1 || bus.src_o !== 1'b0 || bus.x !== 12'h005) begin errors++; $display("FAIL bp_load: got stb=%0b src=%0b x=%0h want 1/0/5", bus.pipe_stb_o, bus.src_o, bus.x); end
    bus.pipe_ack_i = 1'b0; bus.a_x = 12'h009;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.a_ack_o !== 1'b0 || bus.b_ack_o !== 1'b0) begin errors++; $display("FAIL bp_ack[%0d]: got a=%0b b=%0b want 0/0", i, bus.a_ack_o, bus.b_ack_o); end
      tick();
      checks++; if (bus.pipe_stb_o !== 1'b1 || bus.src_o !== 1'b0 || bus.x !== 12'h005) begin errors++; $display("FAIL bp_hold[%0d]: got stb=%0b src=%0b x=%0h want 1/0/5", i, bus.pipe_stb_o, bus.src_o, bus.x); end
    end
    bus.pipe_ack_i = 1'b1;
    #1;
    checks++; if (bus.b_ack_o !== 1'b1 || bus.a_ack_o !== 1'b0) begin errors++; $display("FAIL bp_release_ack: got a=%0b b=%0b want 0/1", bus.a_ack_o, bus.b_ack_o); end
    tick();
    checks++; if (bus.pipe_stb_o !== 1'b1 || bus.src_o !== 1'b1 || bus.x !== 12'hFF9) begin errors++; $display("FAIL bp_release_out: got stb=%0b src=%0b x=%0h want 1/1/ff9", bus.pipe_stb_o, bus.src_o, bus.x); end
  endtask

  task automatic test_hold();
    bus.b_stb_i = 1'b0; bus.a_stb_i = 1'b1; bus.a_x = 12'h123; hold = 1'b1;
    #1;
    checks++; if (bus.a_ack_o !== 1'b0) begin errors++; $display("FAIL hold_ack0: got %0b want 0", bus.a_ack_o); end
    tick();
    checks++; if (bus.pipe_stb_o !== 1'b0 || bus.a_ack_o !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL hold_drain: got stb=%0b ack=%0b busy=%0b want 0/0/1", bus.pipe_stb_o, bus.a_ack_o, busy); end
    tick();
    checks++; if (bus.pipe_stb_o !== 1'b0) begin errors++; $display("FAIL hold_idle: got stb=%0b want 0", bus.pipe_stb_o); end
    hold = 1'b0;
    #1;
    checks++; if (bus.a_ack_o !== 1'b1) begin errors++; $display("FAIL hold_release_ack: got %0b want 1", bus.a_ack_o); end
    tick();
    checks++; if (bus.pipe_stb_o !== 1'b1 || bus.src_o !== 1'b0 || bus.x !== 12'h123) begin errors++; $display("FAIL hold_release_out: got stb=%0b src=%0b x=%0h want 1/0/123", bus.pipe_stb_o, bus.src_o, bus.x); end
    bus.a_stb_i = 1'b0;
    tick();
  endtask

  task automatic test_counters();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    bus.a_stb_i = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (cnt_a !== 4'd15) begin errors++; $display("FAIL cnt_max: got %0d want 15", cnt_a); end
    tick();
    checks++; if (cnt_a !== 4'd0) begin errors++; $display("FAIL cnt_wrap: got %0d want 0", cnt_a); end
    tick(); tick();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    checks++; if (cnt_a !== 4'd1 || cnt_b !== 4'd0) begin errors++; $display("FAIL cnt_clear_accept: got %0d/%0d want 1/0", cnt_a, cnt_b); end
    bus.a_stb_i = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || bus.pipe_stb_o !== 1'b0) begin errors++; $display("FAIL idle_end: got busy=%0b stb=%0b want 0/0", busy, bus.pipe_stb_o); end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_only_b();
    test_backpressure();
    test_hold();
    test_counters();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
